// File: rtl/dmem_access_unit.sv
// DMAR/DMDR register pair with a sequencer for pixel reads and writes to the external image memory.
// Latency: a read accepted on edge N gives done in cycle N+RD_LAT+2; a write gives done in cycle N+2.
// Backpressure: no queueing; requests and register loads are ignored while busy, and requests are ignored in FINISH.
module dmem_access_unit #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 18,
  parameter int PIX_W  = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] c_bus,
  input  logic              ld_dmar,
  input  logic              ld_dmdr,
  input  logic              inc_dmar,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dmar,
  output logic [DATA_W-1:0] dmdr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_WR_ISSUE = 3'd3;
  localparam logic [2:0] S_FINISH   = 3'd4;

  // The wait state runs RD_LAT cycles (counter RD_LAT-1 down to 0), so the
  // capture edge lands exactly RD_LAT edges after the issue edge.
  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  logic [2:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] dmar_q, dmar_d;
  logic [DATA_W-1:0] dmdr_q, dmdr_d;
  logic              regs_open;

  // Loads are only accepted when no transfer holds the address/data stable.
  assign regs_open = (state_q == S_IDLE) || (state_q == S_FINISH);

  // Next-state, latency counter and register-update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dmar_d  = dmar_q;
    dmdr_d  = dmdr_q;

    if (regs_open) begin
      if (ld_dmar) begin
        dmar_d = c_bus;
      end else if (inc_dmar) begin
        dmar_d = dmar_q + DATA_W'(1);
      end
      if (ld_dmdr) begin
        dmdr_d = c_bus;
      end
    end

    case (state_q)
      S_IDLE: begin
        // Read wins; a simultaneous write is dropped, not deferred.
        if (rd_req) begin
          state_d = S_RD_ISSUE;
        end else if (wr_req) begin
          state_d = S_WR_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          dmdr_d  = DATA_W'(mem_rdata);
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WR_ISSUE: state_d = S_FINISH;
      S_FINISH:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // State and register flops; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      dmar_q  <= '0;
      dmdr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dmar_q  <= dmar_d;
      dmdr_q  <= dmdr_d;
    end
  end

  assign busy      = (state_q == S_RD_ISSUE) || (state_q == S_RD_WAIT) || (state_q == S_WR_ISSUE);
  assign done      = (state_q == S_FINISH);
  assign mem_en    = (state_q == S_RD_ISSUE) || (state_q == S_WR_ISSUE);
  assign mem_we    = (state_q == S_WR_ISSUE);
  assign dmar      = dmar_q;
  assign dmdr      = dmdr_q;
  assign mem_addr  = dmar_q[ADDR_W-1:0];
  assign mem_wdata = dmdr_q[PIX_W-1:0];

endmodule
